// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32 M-extension multiply/divide sequencer.
package mdu_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension unit: one shift-add / restoring shift-subtract step per cycle,
// operating on operand magnitudes with a final sign fix-up.
module muldiv_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            res,
    input  logic            start_EX,
    input  logic [2:0]      funct3_EX,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall_EX
);

    state_t              r_state;
    state_t              w_stateNext;
    logic [CNT_W-1:0]    r_count;
    logic [2:0]          r_funct3;
    logic [XLEN-1:0]     r_opB;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_negMain;
    logic                r_negRem;
    logic [XLEN-1:0]     r_result;

    logic                w_aSigned;
    logic                w_bSigned;
    logic                w_aNeg;
    logic                w_bNeg;
    logic [XLEN-1:0]     w_aMag;
    logic [XLEN-1:0]     w_bMag;
    logic                w_divZero;
    logic                w_overflow;
    logic                w_fast;
    logic [XLEN-1:0]     w_fastResult;
    logic                w_accept;

    logic [XLEN:0]       w_mulSum;
    logic [2*XLEN-1:0]   w_mulStep;
    logic [XLEN:0]       w_divShift;
    logic                w_divOk;
    logic [XLEN-1:0]     w_divSub;
    logic [2*XLEN-1:0]   w_divStep;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_fixResult;

    // Only the unsigned-operand ops skip the magnitude conversion; MULHSU treats b as unsigned
    assign w_aSigned = (funct3_EX != F3_MULHU) && (funct3_EX != F3_DIVU) && (funct3_EX != F3_REMU);
    assign w_bSigned = (funct3_EX == F3_MUL) || (funct3_EX == F3_MULH) ||
                       (funct3_EX == F3_DIV) || (funct3_EX == F3_REM);
    assign w_aNeg    = w_aSigned && a[XLEN-1];
    assign w_bNeg    = w_bSigned && b[XLEN-1];
    assign w_aMag    = w_aNeg ? neg32(a) : a;
    assign w_bMag    = w_bNeg ? neg32(b) : b;

    assign w_divZero  = funct3_EX[2] && (b == '0);
    assign w_overflow = ((funct3_EX == F3_DIV) || (funct3_EX == F3_REM)) &&
                        (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_fast     = w_divZero || w_overflow;
    assign w_fastResult = w_divZero ? (funct3_EX[1] ? a : '1)
                                    : (funct3_EX[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    assign w_accept   = (r_state == IDLE) && start_EX;

    // Multiply: low half of the accumulator is the multiplier, shifted out LSB first
    assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opB : '0)};
    assign w_mulStep = {w_mulSum, r_acc[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts the dividend out and quotient in
    assign w_divShift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_divOk    = (w_divShift >= {1'b0, r_opB});
    assign w_divSub   = w_divShift[XLEN-1:0] - r_opB;
    assign w_divStep  = {(w_divOk ? w_divSub : w_divShift[XLEN-1:0]), r_acc[XLEN-2:0], w_divOk};

    assign w_prod = r_negMain ? -r_acc : r_acc;

    always_comb begin
        w_fixResult = '0;
        case (r_funct3)
            F3_MUL:                      w_fixResult = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fixResult = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             w_fixResult = r_negMain ? neg32(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
            default:                     w_fixResult = r_negRem ? neg32(r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        stall_EX    = 1'b0;
        done        = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start_EX) begin
                    stall_EX    = 1'b1;
                    w_stateNext = w_fast ? DONE : CALC;
                end
            end
            CALC: begin
                stall_EX = 1'b1;
                if (r_count == CNT_W'(XLEN-1)) begin
                    w_stateNext = FIX;
                end
            end
            FIX: begin
                stall_EX    = 1'b1;
                w_stateNext = DONE;
            end
            default: begin
                done        = 1'b1;
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_count   <= '0;
            r_funct3  <= '0;
            r_opB     <= '0;
            r_acc     <= '0;
            r_negMain <= 1'b0;
            r_negRem  <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= funct3_EX;
                        r_opB     <= w_bMag;
                        r_acc     <= {{XLEN{1'b0}}, w_aMag};
                        r_negMain <= w_aNeg ^ w_bNeg;
                        r_negRem  <= w_aNeg;
                        r_count   <= '0;
                        if (w_fast) begin
                            r_result <= w_fastResult;
                        end
                    end
                end
                CALC: begin
                    r_count <= r_count + CNT_W'(1);
                    r_acc   <= r_funct3[2] ? w_divStep : w_mulStep;
                end
                FIX: begin
                    r_result <= w_fixResult;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus queues expected result, done cycle and stall length;
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start_EX = 1'b0;
    logic [2:0]  funct3_EX = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        stall_EX;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stallRun = 0;

    logic [31:0] expQ[$];
    int          cycQ[$];
    int          stallQ[$];

    muldiv_seq dut (
        .clk       (clk),
        .res       (res),
        .start_EX  (start_EX),
        .funct3_EX (funct3_EX),
        .a         (a),
        .b         (b),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .stall_EX  (stall_EX)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Waits for the unit to be idle, with a cycle budget
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] expv, input bit fast, output int startCyc);
        waitIdle();
        @(posedge clk);
        #1;
        start_EX  = 1'b1;
        funct3_EX = f3;
        a         = av;
        b         = bv;
        startCyc  = cyc;
        expQ.push_back(expv);
        cycQ.push_back(cyc + (fast ? 1 : 34));
        stallQ.push_back(fast ? 1 : 34);
        #1;
        checkOutput("stall_at_start", {31'b0, stall_EX}, 32'd1);
        @(posedge clk);
        #1;
        start_EX = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
    endtask

    // Monitor: counts stall cycles per op and scores every done pulse
    initial begin
        logic [31:0] e;
        int ec;
        int es;
        forever begin
            @(negedge clk);
            if (!res) begin
                stallRun = 0;
            end else begin
                if (stall_EX) stallRun++;
                if (done) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done actual=%h required=no_done", result);
                    end else begin
                        e  = expQ.pop_front();
                        ec = cycQ.pop_front();
                        es = stallQ.pop_front();
                        checkOutput("result", result, e);
                        checkOutput("done_cycle", 32'(cyc), 32'(ec));
                        checkOutput("stall_cycles", 32'(stallRun), 32'(es));
                    end
                    stallRun = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall_EX}, 32'd0);
        @(posedge clk);
        #1 res = 1'b1;

        // MUL 7 * -3 with full latency profile
        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, s);
        while (cyc < s + 35) @(negedge clk);
        checkOutput("busy_cycle35", {31'b0, busy}, 32'd0);
        checkOutput("done_cycle35", {31'b0, done}, 32'd0);

        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, s);
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, s);
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, s);

        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, s);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, s);
        applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, s);
        applyStimulus(3'b111, 32'd100, 32'd7, 32'd2, 1'b0, s);

        applyStimulus(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, s);
        applyStimulus(3'b110, 32'd5, 32'd0, 32'd5, 1'b1, s);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, s);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, s);

        // start_EX held through DONE: second op accepted in the following IDLE cycle
        waitIdle();
        @(posedge clk);
        #1;
        start_EX  = 1'b1;
        funct3_EX = 3'b101;
        a         = 32'd100;
        b         = 32'd7;
        s         = cyc;
        expQ.push_back(32'd14);
        cycQ.push_back(s + 34);
        stallQ.push_back(34);
        expQ.push_back(32'd12);
        cycQ.push_back(s + 69);
        stallQ.push_back(34);
        @(posedge clk);
        #1;
        funct3_EX = 3'b000;
        a         = 32'd3;
        b         = 32'd4;
        while (cyc < s + 36) begin
            @(posedge clk);
            #1;
        end
        start_EX = 1'b0;

        // Reset abandons an operation in progress
        applyStimulus(3'b000, 32'd11, 32'd13, 32'd0, 1'b0, s);
        void'(expQ.pop_back());
        void'(cycQ.pop_back());
        void'(stallQ.pop_back());
        while (cyc < s + 10) begin
            @(posedge clk);
            #1;
        end
        res = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_stall", {31'b0, stall_EX}, 32'd0);
        @(posedge clk);
        #1 res = 1'b1;

        applyStimulus(3'b101, 32'd9, 32'd3, 32'd3, 1'b0, s);

        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the RV32 M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the ALU in the execute stage and takes operands from regfile readdata1/readdata2.
- Freezes fetch/execute through stall_EX while an op runs, then presents one result for writeback.
- Contains a single shared shift/add-subtract datapath, sequenced by an FSM and a 5-bit iteration counter.

Parameters:
- XLEN, 32, operand/result width (only 32 is supported).
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk  in  1  system clock.
- res  in  1  reset, synchronous, active-low.
- start_EX  in  1  decoded M-op present in execute stage.
- funct3_EX  in  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  32  rs1 operand.
- b  in  32  rs2 operand.
- result  out  32  product/quotient/remainder.
- done  out  1  result valid, one-cycle pulse.
- busy  out  1  FSM not in IDLE.
- stall_EX  out  1  hold PC and execute-stage instruction register.

Behaviour:
- Reset (res==0 at posedge clk):
  - state=IDLE, counter=0, result=0, done=0, busy=0.
  - Internal operand/accumulator registers cleared.
  - Applies in any state, including mid-operation: the operation is abandoned and no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start_EX=1, latch funct3, |a|, |b| (magnitudes only for signed operands per op), and the result sign flags.
  - Normal next state is CALC with counter=0.
  - Fast path, next state DONE:
    - Divide by zero (b==0): quotient=32'hFFFF_FFFF (DIV/DIVU), remainder=a (REM/REMU).
    - Signed overflow (DIV/REM, a==32'h8000_0000, b==32'hFFFF_FFFF): quotient=32'h8000_0000, remainder=0.
- CALC: one iteration per cycle for exactly 32 cycles; leave for FIX when counter==31, and counter wraps to 0.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring shift-subtract with a 33-bit partial remainder.
- FIX (1 cycle):
  - Two's-complement negate where required:
    - product when sign(a) xor sign(b) (MUL/MULH; MULHSU uses sign(a) only);
    - quotient when signs differ;
    - remainder takes sign of dividend.
  - Select low word (MUL), high word (MULH*), quotient or remainder into the result register.
- DONE (1 cycle): done=1; result holds its value until the next accepted start or reset; next state IDLE.
- start_EX is ignored in CALC, FIX and DONE. A back-to-back M-op is accepted in the IDLE cycle after DONE.
- stall_EX = (state==IDLE & start_EX) | state==CALC | state==FIX. It is combinational and deasserts in DONE so the pipeline advances at the end of that cycle.
- busy = (state != IDLE).
- Latency from the start cycle (cycle 0): normal done at cycle 34, stall_EX high cycles 0..33; fast path done at cycle 1, stall_EX high cycle 0 only.
- Operands a/b are sampled only in IDLE at start; later changes have no effect.
- All arithmetic is modulo 2^32 on result; the intermediate product is 64 bits.

Decomposition:
- mdu_pkg holds:
  - state_t enum {IDLE, CALC, FIX, DONE};
  - funct3 localparams F3_MUL..F3_REMU;
  - XLEN and CNT_W defaults.
- No sub-module: FSM, counter and datapath stay in muldiv_seq. An optional combinational helper neg32 may live in mdu_pkg as a function.

Test Plan:
1. MUL a=7, b=32'hFFFF_FFFD at cycle 0 -> stall_EX high cycles 0..33, done pulse cycle 34, result=32'hFFFF_FFEB, busy low cycle 35.
2. a=b=32'hFFFF_FFFF with MULHU / MULH / MULHSU -> 32'hFFFF_FFFE / 32'h0000_0000 / 32'hFFFF_FFFF respectively.
3. DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each done at cycle 34.
4. Fast path: DIVU 5/0 -> 32'hFFFF_FFFF and REM 5/0 -> 5, done at cycle 1; DIV 32'h8000_0000/32'hFFFF_FFFF -> 32'h8000_0000, REM same operands -> 0, done at cycle 1.
5. start_EX held high through DONE with a new MUL 3*4 -> first op completes, second is accepted in the following IDLE cycle, result=12 exactly 34 cycles later; no op is double-accepted.
6. res driven low at cycle 10 of CALC -> next cycle state IDLE, busy=0, done=0, result=0, stall_EX=0 with start_EX low; a subsequent DIVU 9/3 returns 3 normally.
